vcm_i2c_target: RTL and testbench
=================================

Name: vcm_i2c_target

Overview:
Synthesizable I2C target emulating the lens VCM driver that the autofocus I2C master writes to each frame. It decodes START/STOP, matches a 7-bit device address, ACKs and captures the 2-byte VCM word, and returns the stored word on read. The master can then run its write-read-write test mode against it. It sits on the SCL/SDA pins in place of, or in parallel with, the camera VCM for bring-up and in-system loopback checks. All sampling runs on CLK_50; SCL is treated as data, never as a clock.

Parameters:
DEV_ADDR, 7'h0C, 7-bit target address (write byte 8'h18, read byte 8'h19)
FILT_LEN, 3, CLK_50 samples a line must hold a new level before it is accepted
RESET_DATA, 16'h0000, VCM_DATA value after reset

Ports:
CLK_50  input  1  system clock, 50 MHz
RESET_N  input  1  asynchronous active-low reset
SCL  input  1  I2C clock from the master
SDA_IN  input  1  sampled SDA pin level
SDA_OE  output  1  1 = pull SDA low; the top level drives SDA to 1'bz when 0
VCM_DATA  output  16  last committed VCM word, {byte1, byte2}
VCM_WR  output  1  one-cycle pulse when VCM_DATA updates
BUSY  output  1  high from an accepted address match until STOP
NACK_CNT  output  8  saturating count of NACKed bytes, for STATUS debug

Behaviour:
- Reset is asynchronous and active-low; the block uses one clock, CLK_50. Reset values: SDA_OE=0, VCM_DATA=RESET_DATA, VCM_WR=0, BUSY=0, NACK_CNT=0, FSM=IDLE. Reset asserted mid-transfer releases SDA on the same edge.
- Input path: 2-FF synchronizer, then a FILT_LEN-sample stability filter on each line. Filtered edges lag the pin by 2+FILT_LEN cycles. Pulses shorter than FILT_LEN cycles are ignored.
- START: filtered SDA falls while filtered SCL is high. STOP: filtered SDA rises while filtered SCL is high. Both are recognized in every state, including repeated START.
- Data is sampled on the filtered SCL rising edge. SDA_OE changes only on the filtered SCL falling edge, plus 1 cycle.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_MACK, WAIT_STOP.
  - IDLE: on START, go to ADDR with bit_cnt=0.
  - ADDR: shift 8 bits MSB first. If addr[7:1]==DEV_ADDR, go to ADDR_ACK; otherwise go to WAIT_STOP and never drive SDA.
  - ADDR_ACK: drive low for the 9th clock. Then go to WR_BYTE if R/W=0, or to RD_BYTE if R/W=1 (byte_idx=0).
  - WR_BYTE: shift 8 bits into the shadow register. At bytes 0 and 1, go to WR_ACK and ACK. At byte_idx>=2, do not drive SDA (NACK), increment NACK_CNT, and go to WAIT_STOP.
  - WR_ACK: after the ACK of byte_idx 1, on SCL falling, set VCM_DATA=shadow and pulse VCM_WR. Then return to WR_BYTE.
  - RD_BYTE: drive VCM_DATA[15:8], then VCM_DATA[7:0], then 8'h00 for any further bytes. SDA_OE = ~bit. Release SDA for the 9th clock and go to RD_MACK.
  - RD_MACK: sample the master ACK. ACK (0) returns to RD_BYTE. NACK (1) goes to WAIT_STOP.
  - WAIT_STOP: SDA released; leave only on STOP or START.
- STOP in any state: go to IDLE, release SDA, clear BUSY. A partial write of 0 or 1 byte never commits, and VCM_DATA stays unchanged.
- START inside any byte: abort the byte, discard the shadow, go to ADDR.
- NACK_CNT saturates at 8'hFF and does not count address mismatches.

Decomposition:
- Shared package vcm_i2c_pkg: FSM state enum, VCM_DEV_ADDR=7'h0C, I2C_WR=1'b0, I2C_RD=1'b1, and the byte-count limit 2. The master side reuses these constants.
- One sub-module, i2c_line_filter: synchronizer, glitch filter, and rise/fall strobes for one line, instantiated for SCL and SDA_IN.

Test Plan:
- Write 8'h18, 8'h3F, 8'hF0, STOP at 100 kHz -> ACK low on all three 9th clocks; VCM_DATA=16'h3FF0; VCM_WR exactly one pulse after the 2nd data ACK.
- Write 8'h1A, 8'h12, 8'h34 -> SDA_OE never asserts; VCM_DATA unchanged; BUSY stays 0.
- After VCM_DATA=16'h3FF0, send 8'h19, read 2 bytes with master ACK then NACK, STOP -> bus shows 8'h3F, 8'hF0; SDA released at STOP.
- Write 8'h18, 8'h55, then repeated START, 8'h18, 8'h01, 8'h02, STOP -> VCM_DATA=16'h0102; no commit of 8'h55.
- Write 8'h18, 8'h11, 8'h22, 8'h33 -> 3rd byte NACKed; NACK_CNT=1; VCM_DATA=16'h1122.
- 2-cycle low glitch on SCL during a data bit -> ignored, byte intact. Assert RESET_N low mid-byte -> SDA_OE=0 the same cycle; VCM_DATA=16'h0000.

Source files
------------

// File: rtl/vcm_i2c_pkg.sv
// Shared definitions for the VCM I2C target and the autofocus master that
// talks to it: bus constants, the byte-count limit of a VCM word, and the
// target FSM state encoding.
package vcm_i2c_pkg;

   // 7-bit address of the lens VCM driver (write byte 8'h18, read byte 8'h19)
   localparam logic [6:0] VCM_DEV_ADDR = 7'h0C;

   // R/W bit values in the address byte
   localparam logic I2C_WR = 1'b0;
   localparam logic I2C_RD = 1'b1;

   // Number of data bytes that make up one VCM word
   localparam int unsigned VCM_BYTE_LIMIT = 2;

   // Target protocol states
   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WR_BYTE,
      WR_ACK,
      RD_BYTE,
      RD_MACK,
      WAIT_STOP
   } i2c_state_e;

   // Byte returned on a read: high byte, low byte, then zero padding
   function automatic logic [7:0] rd_byte_sel(input logic [15:0] word,
                                              input logic [1:0]  idx);
      logic [7:0] sel;
      case (idx)
         2'd0:    sel = word[15:8];
         2'd1:    sel = word[7:0];
         default: sel = 8'h00;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Conditions one open-drain I2C line for use in the CLK_50 domain:
// two-flop synchronizer, a FILT_LEN-sample stability filter, and one-cycle
// rise/fall strobes that coincide with the new filtered level.
module i2c_line_filter #(
   parameter int FILT_LEN = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic line,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   // Synchronize the pin, then accept a new level only after it has held
   // for FILT_LEN consecutive samples; shorter pulses reset the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: both lines idle high on an I2C bus, so the synchronizer and
         // filter reset to 1; resetting to 0 would fake a rising edge.
         sync  <= 2'b11;
         level <= 1'b1;
         cnt   <= '0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every flop sample the values
         // from before this edge, so the sync chain really is two stages.
         sync <= {sync[0], line};
         rise <= 1'b0;
         fall <= 1'b0;
         if (sync[1] != level) begin
            if (cnt == CW'(FILT_LEN - 1)) begin
               level <= sync[1];
               cnt   <= '0;
               rise  <= sync[1];
               fall  <= ~sync[1];
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/vcm_i2c_target.sv
// I2C target that stands in for the camera lens VCM driver. It accepts the
// 2-byte VCM word written by the autofocus master, commits it after the
// second data ACK, and returns the stored word on a read. SCL is sampled as
// data on CLK_50; nothing here is clocked by SCL.
module vcm_i2c_target
   import vcm_i2c_pkg::*;
#(
   parameter logic [6:0]  DEV_ADDR   = VCM_DEV_ADDR,
   parameter int          FILT_LEN   = 3,
   parameter logic [15:0] RESET_DATA = 16'h0000
) (
   input  logic        CLK_50,
   input  logic        RESET_N,
   input  logic        SCL,
   input  logic        SDA_IN,
   output logic        SDA_OE,
   output logic [15:0] VCM_DATA,
   output logic        VCM_WR,
   output logic        BUSY,
   output logic [7:0]  NACK_CNT
);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;
   logic start_det, stop_det;

   i2c_state_e  state, state_n;
   logic [3:0]  bit_cnt, bit_cnt_n;     // SCL rising edges seen in this byte
   logic [1:0]  byte_idx, byte_idx_n;   // data byte index, saturates at limit
   logic [6:0]  shreg, shreg_n;         // first seven bits of incoming byte
   logic [6:0]  tx, tx_n;               // remaining bits of outgoing byte
   logic [15:0] shadow, shadow_n;       // write word before commit
   logic        rw, rw_n;
   logic        oe_n, busy_n, wr_n;
   logic [15:0] data_n;
   logic [7:0]  nack_n;
   logic [7:0]  rd_byte;

   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
      .clk   (CLK_50),
      .rst_n (RESET_N),
      .line  (SCL),
      .level (scl_lvl),
      .rise  (scl_rise),
      .fall  (scl_fall)
   );

   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
      .clk   (CLK_50),
      .rst_n (RESET_N),
      .line  (SDA_IN),
      .level (sda_lvl),
      .rise  (sda_rise),
      .fall  (sda_fall)
   );

   // SDA moving while SCL is high marks bus conditions, never data
   assign start_det = sda_fall & scl_lvl;
   assign stop_det  = sda_rise & scl_lvl;

   // Register FSM state and every output, so SDA_OE moves one cycle after
   // the filtered SCL fall and reset releases SDA immediately.
   always_ff @(posedge CLK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         byte_idx <= '0;
         shreg    <= '0;
         tx       <= '0;
         shadow   <= '0;
         rw       <= I2C_WR;
         SDA_OE   <= 1'b0;
         BUSY     <= 1'b0;
         VCM_DATA <= RESET_DATA;
         VCM_WR   <= 1'b0;
         NACK_CNT <= '0;
      end else begin
         state    <= state_n;
         bit_cnt  <= bit_cnt_n;
         byte_idx <= byte_idx_n;
         shreg    <= shreg_n;
         tx       <= tx_n;
         shadow   <= shadow_n;
         rw       <= rw_n;
         SDA_OE   <= oe_n;
         BUSY     <= busy_n;
         VCM_DATA <= data_n;
         VCM_WR   <= wr_n;
         NACK_CNT <= nack_n;
      end
   end

   // Next-state and output decode: STOP wins, then START, then SCL edges
   // within the current state. Bits are taken on SCL rise; SDA_OE is only
   // changed on SCL fall.
   always_comb begin
      // NOTE: every variable gets its hold value first, so paths that do
      // not assign it cannot infer a latch.
      state_n    = state;
      bit_cnt_n  = bit_cnt;
      byte_idx_n = byte_idx;
      shreg_n    = shreg;
      tx_n       = tx;
      shadow_n   = shadow;
      rw_n       = rw;
      oe_n       = SDA_OE;
      busy_n     = BUSY;
      data_n     = VCM_DATA;
      wr_n       = 1'b0;
      nack_n     = NACK_CNT;
      rd_byte    = 8'h00;

      if (stop_det) begin
         state_n    = IDLE;
         oe_n       = 1'b0;
         busy_n     = 1'b0;
         bit_cnt_n  = '0;
         byte_idx_n = '0;
      end else if (start_det) begin
         // Covers repeated START: any byte in flight and the shadow word
         // are abandoned.
         state_n    = ADDR;
         oe_n       = 1'b0;
         bit_cnt_n  = '0;
         byte_idx_n = '0;
         shadow_n   = '0;
      end else begin
         unique case (state)
            IDLE: begin
               oe_n = 1'b0;
            end

            ADDR: begin
               if (scl_rise) begin
                  shreg_n = {shreg[5:0], sda_lvl};
                  if (bit_cnt == 4'd7) begin
                     // shreg holds the 7 address bits, the 8th is R/W
                     if (shreg == DEV_ADDR) begin
                        state_n   = ADDR_ACK;
                        busy_n    = 1'b1;
                        rw_n      = sda_lvl;
                        bit_cnt_n = 4'd8;
                     end else begin
                        state_n = WAIT_STOP;
                     end
                  end else begin
                     bit_cnt_n = bit_cnt + 4'd1;
                  end
               end
            end

            ADDR_ACK: begin
               if (scl_rise) begin
                  bit_cnt_n = 4'd9;
               end else if (scl_fall) begin
                  if (bit_cnt == 4'd8) begin
                     oe_n = 1'b1;
                  end else begin
                     bit_cnt_n  = '0;
                     byte_idx_n = '0;
                     if (rw == I2C_RD) begin
                        rd_byte = rd_byte_sel(VCM_DATA, 2'd0);
                        state_n = RD_BYTE;
                        oe_n    = ~rd_byte[7];
                        tx_n    = rd_byte[6:0];
                     end else begin
                        state_n = WR_BYTE;
                        oe_n    = 1'b0;
                     end
                  end
               end
            end

            WR_BYTE: begin
               if (scl_rise) begin
                  shreg_n = {shreg[5:0], sda_lvl};
                  if (bit_cnt == 4'd7) begin
                     if (byte_idx < 2'(VCM_BYTE_LIMIT)) begin
                        if (byte_idx == 2'd0) shadow_n[15:8] = {shreg, sda_lvl};
                        else                  shadow_n[7:0]  = {shreg, sda_lvl};
                        state_n   = WR_ACK;
                        bit_cnt_n = 4'd8;
                     end else begin
                        // Surplus byte: leave SDA released so the master
                        // sees a NACK on the 9th clock.
                        state_n = WAIT_STOP;
                        if (NACK_CNT != 8'hFF) nack_n = NACK_CNT + 8'd1;
                     end
                  end else begin
                     bit_cnt_n = bit_cnt + 4'd1;
                  end
               end
            end

            WR_ACK: begin
               if (scl_rise) begin
                  bit_cnt_n = 4'd9;
               end else if (scl_fall) begin
                  if (bit_cnt == 4'd8) begin
                     oe_n = 1'b1;
                  end else begin
                     oe_n       = 1'b0;
                     bit_cnt_n  = '0;
                     state_n    = WR_BYTE;
                     byte_idx_n = byte_idx + 2'd1;
                     // Word is complete only once the last byte's ACK clock
                     // has finished.
                     if (byte_idx == 2'(VCM_BYTE_LIMIT - 1)) begin
                        data_n = shadow;
                        wr_n   = 1'b1;
                     end
                  end
               end
            end

            RD_BYTE: begin
               if (scl_rise) begin
                  if (bit_cnt != 4'd8) bit_cnt_n = bit_cnt + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt == 4'd8) begin
                     oe_n    = 1'b0;
                     state_n = RD_MACK;
                  end else begin
                     oe_n = ~tx[6];
                     tx_n = {tx[5:0], 1'b0};
                  end
               end
            end

            RD_MACK: begin
               if (scl_rise) begin
                  if (sda_lvl) state_n = WAIT_STOP;
                  else         bit_cnt_n = 4'd9;
               end else if (scl_fall && bit_cnt == 4'd9) begin
                  byte_idx_n = (byte_idx == 2'(VCM_BYTE_LIMIT)) ? byte_idx
                                                                : byte_idx + 2'd1;
                  rd_byte    = rd_byte_sel(VCM_DATA, byte_idx_n);
                  bit_cnt_n  = '0;
                  state_n    = RD_BYTE;
                  oe_n       = ~rd_byte[7];
                  tx_n       = rd_byte[6:0];
               end
            end

            WAIT_STOP: begin
               oe_n = 1'b0;
            end

            default: begin
               state_n = IDLE;
               oe_n    = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vcm_i2c_target.sv
// Directed bench for vcm_i2c_target: a bit-banged I2C master on an
// open-drain bus model, with hand-computed expectations per scenario.
module tb_vcm_i2c_target;

   logic        CLK_50;
   logic        RESET_N;
   logic        m_scl;
   logic        m_sda;
   logic        sda_bus;
   logic        SDA_OE;
   logic [15:0] VCM_DATA;
   logic        VCM_WR;
   logic        BUSY;
   logic [7:0]  NACK_CNT;

   int q = 25;              // CLK_50 cycles per quarter SCL period
   int vectors = 0;
   int miscompares = 0;
   int wr_pulses = 0;
   int oe_cycles = 0;
   int busy_cycles = 0;

   assign sda_bus = m_sda & ~SDA_OE;

   vcm_i2c_target dut (
      .CLK_50   (CLK_50),
      .RESET_N  (RESET_N),
      .SCL      (m_scl),
      .SDA_IN   (sda_bus),
      .SDA_OE   (SDA_OE),
      .VCM_DATA (VCM_DATA),
      .VCM_WR   (VCM_WR),
      .BUSY     (BUSY),
      .NACK_CNT (NACK_CNT)
   );

   initial CLK_50 = 1'b0;
   always #10 CLK_50 = ~CLK_50;

   // Event counters for pulses and levels that must or must not occur
   always @(negedge CLK_50) begin
      if (VCM_WR) wr_pulses++;
      if (SDA_OE) oe_cycles++;
      if (BUSY)   busy_cycles++;
   end

   task automatic wait_q(input int n);
      repeat (n) @(negedge CLK_50);
   endtask

   // One SCL clock; returns the bus level seen in the middle of SCL high
   task automatic clock_bit(input logic b, input logic glitch, output logic seen);
      m_sda = b;
      wait_q(q);
      m_scl = 1'b1;
      wait_q(q);
      seen = sda_bus;
      if (glitch) begin
         m_scl = 1'b0;
         wait_q(2);
         m_scl = 1'b1;
      end
      wait_q(q);
      m_scl = 1'b0;
      wait_q(q);
   endtask

   task automatic i2c_start();
      m_sda = 1'b1;
      wait_q(q);
      m_scl = 1'b1;
      wait_q(q);
      m_sda = 1'b0;
      wait_q(q);
      m_scl = 1'b0;
      wait_q(q);
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0;
      wait_q(q);
      m_scl = 1'b1;
      wait_q(q);
      m_sda = 1'b1;
      wait_q(q);
   endtask

   task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic acked);
      logic s;
      for (int i = 7; i >= 0; i--) clock_bit(b[i], (i == glitch_bit), s);
      clock_bit(1'b1, 1'b0, s);
      acked = ~s;
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] data);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, 1'b0, s);
         data[i] = s;
      end
      clock_bit(mack, 1'b0, s);
   endtask

   task automatic test_reset();
      vectors++;
      if (SDA_OE !== 1'b0) begin miscompares++; $display("FAIL reset_sda_oe: got %b want 0", SDA_OE); end
      vectors++;
      if (VCM_DATA !== 16'h0000) begin miscompares++; $display("FAIL reset_vcm_data: got %h want 0000", VCM_DATA); end
      vectors++;
      if (VCM_WR !== 1'b0) begin miscompares++; $display("FAIL reset_vcm_wr: got %b want 0", VCM_WR); end
      vectors++;
      if (BUSY !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", BUSY); end
      vectors++;
      if (NACK_CNT !== 8'h00) begin miscompares++; $display("FAIL reset_nack_cnt: got %h want 00", NACK_CNT); end
   endtask

   // 100 kHz write of 16'h3FF0
   task automatic test_write_100k();
      logic a;
      int   w0;
      q  = 125;
      w0 = wr_pulses;
      i2c_start();
      write_byte(8'h18, -1, a);
      vectors++;
      if (a !== 1'b1) begin miscompares++; $display("FAIL wr100_addr_ack: got %b want 1", a); end
      vectors++;
      if (BUSY !== 1'b1) begin miscompares++; $display("FAIL wr100_busy: got %b want 1", BUSY); end
      write_byte(8'h3F, -1, a);
      vectors++;
      if (a !== 1'b1) begin miscompares++; $display("FAIL wr100_b0_ack: got %b want 1", a); end
      vectors++;
      if (wr_pulses - w0 !== 0) begin miscompares++; $display("FAIL wr100_early_wr: got %0d pulses want 0", wr_pulses - w0); end
      write_byte(8'hF0, -1, a);
      vectors++;
      if (a !== 1'b1) begin miscompares++; $display("FAIL wr100_b1_ack: got %b want 1", a); end
      vectors++;
      if (wr_pulses - w0 !== 1) begin miscompares++; $display("FAIL wr100_wr_pulse: got %0d pulses want 1", wr_pulses - w0); end
      i2c_stop();
      vectors++;
      if (VCM_DATA !== 16'h3FF0) begin miscompares++; $display("FAIL wr100_data: got %h want 3ff0", VCM_DATA); end
      vectors++;
      if (BUSY !== 1'b0) begin miscompares++; $display("FAIL wr100_busy_stop: got %b want 0", BUSY); end
      vectors++;
      if (wr_pulses - w0 !== 1) begin miscompares++; $display("FAIL wr100_wr_total: got %0d pulses want 1", wr_pulses - w0); end
      q = 25;
   endtask

   // Wrong address (7'h0D): target must stay off the bus
   task automatic test_addr_mismatch();
      logic a0, a1, a2;
      int   oe0, b0;
      oe0 = oe_cycles;
      b0  = busy_cycles;
      i2c_start();
      write_byte(8'h1A, -1, a0);
      write_byte(8'h12, -1, a1);
      write_byte(8'h34, -1, a2);
      i2c_stop();
      vectors++;
      if ({a0, a1, a2} !== 3'b000) begin miscompares++; $display("FAIL mis_acks: got %b want 000", {a0, a1, a2}); end
      vectors++;
      if (oe_cycles - oe0 !== 0) begin miscompares++; $display("FAIL mis_sda_oe: got %0d cycles want 0", oe_cycles - oe0); end
      vectors++;
      if (busy_cycles - b0 !== 0) begin miscompares++; $display("FAIL mis_busy: got %0d cycles want 0", busy_cycles - b0); end
      vectors++;
      if (VCM_DATA !== 16'h3FF0) begin miscompares++; $display("FAIL mis_data: got %h want 3ff0", VCM_DATA); end
      vectors++;
      if (NACK_CNT !== 8'h00) begin miscompares++; $display("FAIL mis_nack_cnt: got %h want 00", NACK_CNT); end
   endtask

   // Read back the stored word: ACK first byte, NACK second
   task automatic test_read();
      logic       a;
      logic [7:0] d0, d1;
      i2c_start();
      write_byte(8'h19, -1, a);
      vectors++;
      if (a !== 1'b1) begin miscompares++; $display("FAIL rd_addr_ack: got %b want 1", a); end
      read_byte(1'b0, d0);
      read_byte(1'b1, d1);
      i2c_stop();
      vectors++;
      if (d0 !== 8'h3F) begin miscompares++; $display("FAIL rd_byte0: got %h want 3f", d0); end
      vectors++;
      if (d1 !== 8'hF0) begin miscompares++; $display("FAIL rd_byte1: got %h want f0", d1); end
      vectors++;
      if (SDA_OE !== 1'b0 || sda_bus !== 1'b1) begin
         miscompares++; $display("FAIL rd_release: got oe=%b bus=%b want oe=0 bus=1", SDA_OE, sda_bus);
      end
      vectors++;
      if (BUSY !== 1'b0) begin miscompares++; $display("FAIL rd_busy_stop: got %b want 0", BUSY); end
   endtask

   // Repeated START after one data byte discards it
   task automatic test_repeated_start();
      logic a;
      int   w0;
      w0 = wr_pulses;
      i2c_start();
      write_byte(8'h18, -1, a);
      write_byte(8'h55, -1, a);
      i2c_start();
      vectors++;
      if (VCM_DATA !== 16'h3FF0) begin miscompares++; $display("FAIL rs_partial: got %h want 3ff0", VCM_DATA); end
      write_byte(8'h18, -1, a);
      vectors++;
      if (a !== 1'b1) begin miscompares++; $display("FAIL rs_addr_ack: got %b want 1", a); end
      write_byte(8'h01, -1, a);
      write_byte(8'h02, -1, a);
      i2c_stop();
      vectors++;
      if (VCM_DATA !== 16'h0102) begin miscompares++; $display("FAIL rs_data: got %h want 0102", VCM_DATA); end
      vectors++;
      if (wr_pulses - w0 !== 1) begin miscompares++; $display("FAIL rs_wr_pulses: got %0d want 1", wr_pulses - w0); end
   endtask

   // Third data byte is NACKed and counted
   task automatic test_overflow_nack();
      logic a0, a1, a2;
      i2c_start();
      write_byte(8'h18, -1, a0);
      write_byte(8'h11, -1, a0);
      write_byte(8'h22, -1, a1);
      write_byte(8'h33, -1, a2);
      i2c_stop();
      vectors++;
      if ({a0, a1, a2} !== 3'b110) begin miscompares++; $display("FAIL ovf_acks: got %b want 110", {a0, a1, a2}); end
      vectors++;
      if (NACK_CNT !== 8'h01) begin miscompares++; $display("FAIL ovf_nack_cnt: got %h want 01", NACK_CNT); end
      vectors++;
      if (VCM_DATA !== 16'h1122) begin miscompares++; $display("FAIL ovf_data: got %h want 1122", VCM_DATA); end
   endtask

   // 2-cycle low pulse on SCL while high must not add a clock
   task automatic test_glitch();
      logic a0, a1, a2;
      i2c_start();
      write_byte(8'h18, -1, a0);
      write_byte(8'hA5, 3, a1);
      write_byte(8'h5A, 6, a2);
      i2c_stop();
      vectors++;
      if ({a0, a1, a2} !== 3'b111) begin miscompares++; $display("FAIL glitch_acks: got %b want 111", {a0, a1, a2}); end
      vectors++;
      if (VCM_DATA !== 16'hA55A) begin miscompares++; $display("FAIL glitch_data: got %h want a55a", VCM_DATA); end
   endtask

   // Reset while the target holds the address ACK, then recover
   task automatic test_reset_mid_byte();
      logic s, a;
      i2c_start();
      for (int i = 7; i >= 0; i--) begin
         logic [7:0] ab;
         ab = 8'h18;
         clock_bit(ab[i], 1'b0, s);
      end
      m_sda = 1'b1;
      vectors++;
      if (SDA_OE !== 1'b1) begin miscompares++; $display("FAIL rst_pre_oe: got %b want 1", SDA_OE); end
      RESET_N = 1'b0;
      #1;
      vectors++;
      if (SDA_OE !== 1'b0) begin miscompares++; $display("FAIL rst_oe_same_cycle: got %b want 0", SDA_OE); end
      vectors++;
      if (VCM_DATA !== 16'h0000) begin miscompares++; $display("FAIL rst_data: got %h want 0000", VCM_DATA); end
      vectors++;
      if (BUSY !== 1'b0 || NACK_CNT !== 8'h00) begin
         miscompares++; $display("FAIL rst_status: got busy=%b nack=%h want 0/00", BUSY, NACK_CNT);
      end
      wait_q(q);
      m_scl = 1'b1;
      wait_q(q);
      RESET_N = 1'b1;
      wait_q(q);
      i2c_start();
      write_byte(8'h18, -1, a);
      write_byte(8'hAB, -1, a);
      write_byte(8'hCD, -1, a);
      i2c_stop();
      vectors++;
      if (VCM_DATA !== 16'hABCD) begin miscompares++; $display("FAIL rst_recover: got %h want abcd", VCM_DATA); end
   endtask

   initial begin
      RESET_N = 1'b0;
      m_scl   = 1'b1;
      m_sda   = 1'b1;
      wait_q(5);
      RESET_N = 1'b1;
      wait_q(10);
      test_reset();
      test_write_100k();
      test_addr_mismatch();
      test_read();
      test_repeated_start();
      test_overflow_nack();
      test_glitch();
      test_reset_mid_byte();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
